// File: rtl/doe_cmd_sequencer_if.sv
// DOE register client bus: select, direction, address, write data, read data, stall.
// Carries no state or latency of its own.
// Stalls with hold: the master keeps cs/we/addr/wdata stable while hold is high.
interface doe_cmd_sequencer_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  cs;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  hold;

  modport master (
    output cs, we, addr, wdata,
    input  rdata, hold
  );

  modport slave (
    input  cs, we, addr, wdata,
    output rdata, hold
  );
endinterface

// File: rtl/doe_cmd_sequencer.sv
// Boot-time DOE command sequencer: per masked command writes IV, control word, then polls status.
// Latency: each bus transaction takes 2 cycles at zero hold; one UDS command runs start-to-done in 13 cycles.
// Backpressure: doe.hold stalls the pending transaction with all bus outputs held stable; abort waits for it.
module doe_cmd_sequencer #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] IV_BASE       = '0,
  parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR     = ADDR_WIDTH'(32'h10),
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR   = ADDR_WIDTH'(32'h14),
  parameter int                    TIMEOUT_POLLS = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           cmd_mask,
  input  logic [127:0]         iv,
  input  logic [4:0]           dest_uds,
  input  logic [4:0]           dest_fe,
  input  logic [4:0]           dest_hek,
  input  logic                 abort,
  doe_cmd_sequencer_if.master  doe,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [3:0]           cmds_done
);

  localparam int PW = $clog2(TIMEOUT_POLLS + 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_IV,
    WR_CTRL,
    POLL_RD,
    POLL_CHK,
    FINISH
  } state_t;

  state_t          state, state_n;
  logic [1:0]      iv_idx, iv_idx_n;
  logic [PW-1:0]   poll_cnt, poll_n, poll_inc;
  logic            gap;
  logic            abort_seen, abort_seen_n, abort_now;
  logic [3:0]      rem, rem_n, rem_after;
  logic [1:0]      cur, cur_n;
  logic [127:0]    iv_q;
  logic [4:0]      dest_uds_q, dest_fe_q, dest_hek_q;
  logic [1:0]      err_code_n;
  logic [3:0]      cmds_done_n;
  logic            err_n;
  logic            zero_done, zero_done_n;
  logic            capture;

  logic                  cs;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic                  accept;
  logic [2:0]            cmd_code;
  logic [4:0]            cmd_dest;
  logic [31:0]           ctrl_word;

  // Command index order is UDS, FE, HEK, CLEAR: pick the lowest pending bit.
  function automatic logic [1:0] low_bit(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign doe.cs    = cs;
  assign doe.we    = we;
  assign doe.addr  = addr;
  assign doe.wdata = wdata;

  assign busy = (state != IDLE);
  // Mask-zero starts never leave IDLE, so their done pulse comes from a flag.
  assign done = (state == FINISH) | zero_done;

  assign abort_now = abort | abort_seen;
  assign rem_after = rem & ~(4'b0001 << cur);
  assign poll_inc  = poll_cnt + PW'(1);

  // Control word fields for the command currently being issued.
  always_comb begin
    cmd_code = 3'd3;
    cmd_dest = 5'd0;
    case (cur)
      2'd0: begin cmd_code = 3'd1; cmd_dest = dest_uds_q; end
      2'd1: begin cmd_code = 3'd2; cmd_dest = dest_fe_q;  end
      2'd2: begin cmd_code = 3'd4; cmd_dest = dest_hek_q; end
      default: begin cmd_code = 3'd3; cmd_dest = 5'd0; end
    endcase
    ctrl_word = {24'd0, cmd_dest, cmd_code};
  end

  // Bus drive: outputs follow registered state only, so they cannot move while hold is high.
  always_comb begin
    cs    = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    case (state)
      WR_IV: begin
        cs    = ~gap;
        we    = 1'b1;
        addr  = IV_BASE + ADDR_WIDTH'({iv_idx, 2'b00});
        wdata = iv_q[{iv_idx, 5'd0} +: 32];
      end
      WR_CTRL: begin
        cs    = ~gap;
        we    = 1'b1;
        addr  = CTRL_ADDR;
        wdata = ctrl_word;
      end
      POLL_RD: begin
        cs    = ~gap;
        addr  = STATUS_ADDR;
      end
      default: ;
    endcase
    accept = cs & ~doe.hold;
  end

  // Next-state and next-value logic for the sequencer.
  always_comb begin
    state_n      = state;
    iv_idx_n     = iv_idx;
    poll_n       = poll_cnt;
    rem_n        = rem;
    cur_n        = cur;
    err_code_n   = err_code;
    cmds_done_n  = cmds_done;
    err_n        = err;
    abort_seen_n = abort_seen | abort;
    zero_done_n  = 1'b0;
    capture      = 1'b0;

    case (state)
      IDLE: begin
        abort_seen_n = 1'b0;
        if (start) begin
          err_n       = 1'b0;
          err_code_n  = 2'd0;
          cmds_done_n = 4'd0;
          if (cmd_mask != 4'd0) begin
            capture  = 1'b1;
            rem_n    = cmd_mask;
            cur_n    = low_bit(cmd_mask);
            iv_idx_n = 2'd0;
            poll_n   = '0;
            state_n  = (low_bit(cmd_mask) == 2'd3) ? WR_CTRL : WR_IV;
          end else begin
            zero_done_n = 1'b1;
          end
        end
      end

      WR_IV: begin
        if (accept) begin
          if (abort_now) begin
            err_code_n = 2'd3;
            state_n    = FINISH;
          end else if (iv_idx == 2'd3) begin
            iv_idx_n = 2'd0;
            state_n  = WR_CTRL;
          end else begin
            iv_idx_n = iv_idx + 2'd1;
          end
        end else if (!cs && abort_now) begin
          err_code_n = 2'd3;
          state_n    = FINISH;
        end
      end

      WR_CTRL: begin
        if (accept) begin
          poll_n = '0;
          if (abort_now) begin
            err_code_n = 2'd3;
            state_n    = FINISH;
          end else begin
            state_n = POLL_RD;
          end
        end else if (!cs && abort_now) begin
          err_code_n = 2'd3;
          state_n    = FINISH;
        end
      end

      // An accepted read always gets its status evaluated, even under abort.
      POLL_RD: begin
        if (accept) begin
          state_n = POLL_CHK;
        end else if (!cs && abort_now) begin
          err_code_n = 2'd3;
          state_n    = FINISH;
        end
      end

      POLL_CHK: begin
        if (doe.rdata[2]) begin
          err_code_n = 2'd1;
          state_n    = FINISH;
        end else if (doe.rdata[1]) begin
          cmds_done_n[cur] = 1'b1;
          rem_n            = rem_after;
          if (abort_now) begin
            err_code_n = 2'd3;
            state_n    = FINISH;
          end else if (rem_after == 4'd0) begin
            state_n = FINISH;
          end else begin
            cur_n    = low_bit(rem_after);
            iv_idx_n = 2'd0;
            state_n  = (low_bit(rem_after) == 2'd3) ? WR_CTRL : WR_IV;
          end
        end else begin
          poll_n = poll_inc;
          if (abort_now) begin
            err_code_n = 2'd3;
            state_n    = FINISH;
          end else if (poll_inc == PW'(TIMEOUT_POLLS)) begin
            err_code_n = 2'd2;
            state_n    = FINISH;
          end else begin
            state_n = POLL_RD;
          end
        end
      end

      FINISH: begin
        err_n        = (err_code != 2'd0);
        abort_seen_n = 1'b0;
        state_n      = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  // State register and captured operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      iv_idx     <= 2'd0;
      poll_cnt   <= '0;
      gap        <= 1'b0;
      abort_seen <= 1'b0;
      rem        <= 4'd0;
      cur        <= 2'd0;
      iv_q       <= '0;
      dest_uds_q <= 5'd0;
      dest_fe_q  <= 5'd0;
      dest_hek_q <= 5'd0;
      err_code   <= 2'd0;
      cmds_done  <= 4'd0;
      err        <= 1'b0;
      zero_done  <= 1'b0;
    end else begin
      state      <= state_n;
      iv_idx     <= iv_idx_n;
      poll_cnt   <= poll_n;
      gap        <= accept;
      abort_seen <= abort_seen_n;
      rem        <= rem_n;
      cur        <= cur_n;
      err_code   <= err_code_n;
      cmds_done  <= cmds_done_n;
      err        <= err_n;
      zero_done  <= zero_done_n;
      if (capture) begin
        iv_q       <= iv;
        dest_uds_q <= dest_uds;
        dest_fe_q  <= dest_fe;
        dest_hek_q <= dest_hek;
      end
    end
  end

endmodule
